osd_dp_packet_buffer: RTL and testbench

//  Store-and-forward DII packet buffer on the debug-processor ingress path, between the

---
 rtl/osd_dp_packet_buffer.sv | 131 +++++++++++++
 tb/tb_osd_dp_packet_buffer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_dp_packet_buffer.sv
// Store-and-forward DII flit buffer: a packet becomes visible downstream only
// once its last flit is stored; packets longer than MAX_PKT_LEN are cut short.
module osd_dp_packet_buffer #(
  parameter int DEPTH       = 16,
  parameter int MAX_PKT_LEN = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [15:0]                in_data,
  input  logic                       in_last,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [15:0]                out_data,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     pkt_count,
  output logic                       trunc_err,
  input  logic                       trunc_err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(MAX_PKT_LEN);

  typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] wr_ptr_reg, commit_ptr_reg, rd_ptr_reg;
  logic [LW-1:0] len_reg;
  logic [PW-1:0] pkt_count_reg;
  logic          trunc_err_reg;

  // Each entry holds {last, data}
  logic [16:0]   mem [DEPTH];

  logic [PW-1:0] used;
  logic          full;
  logic          in_fire, out_fire;
  logic          at_max;
  logic          wr_en, wr_last, commit, trunc;

  assign used     = wr_ptr_reg - rd_ptr_reg;
  assign full     = (used == PW'(DEPTH));
  assign in_ready = (state_reg == DISCARD) || !full;
  assign in_fire  = in_valid && in_ready;

  assign out_valid = (rd_ptr_reg != commit_ptr_reg);
  assign out_data  = mem[rd_ptr_reg[AW-1:0]][15:0];
  assign out_last  = mem[rd_ptr_reg[AW-1:0]][16];
  assign out_fire  = out_valid && out_ready;

  // len_reg counts flits already stored, so the incoming flit is number len_reg+1
  assign at_max = (len_reg == LW'(MAX_PKT_LEN - 1));

  assign pkt_count = pkt_count_reg;
  assign trunc_err = trunc_err_reg;

  always_comb begin
    state_next = state_reg;
    wr_en      = 1'b0;
    wr_last    = 1'b0;
    commit     = 1'b0;
    trunc      = 1'b0;
    case (state_reg)
      IDLE, RECV: begin
        if (in_fire) begin
          wr_en = 1'b1;
          if (in_last || at_max) begin
            wr_last    = 1'b1;
            commit     = 1'b1;
            trunc      = !in_last;
            state_next = in_last ? IDLE : DISCARD;
          end else begin
            state_next = RECV;
          end
        end
      end
      DISCARD: begin
        if (in_fire && in_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      commit_ptr_reg <= '0;
      rd_ptr_reg     <= '0;
      len_reg        <= '0;
      pkt_count_reg  <= '0;
      trunc_err_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (commit) begin
        commit_ptr_reg <= wr_ptr_reg + 1'b1;
        len_reg        <= '0;
      end else if (wr_en) begin
        len_reg <= len_reg + 1'b1;
      end
      if (out_fire) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({commit, out_fire && out_last})
        2'b10:   pkt_count_reg <= pkt_count_reg + 1'b1;
        2'b01:   pkt_count_reg <= pkt_count_reg - 1'b1;
        default: pkt_count_reg <= pkt_count_reg;
      endcase
      // A new truncation outranks a simultaneous clear
      if (trunc) begin
        trunc_err_reg <= 1'b1;
      end else if (trunc_err_clr) begin
        trunc_err_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg[AW-1:0]] <= {wr_last, in_data};
    end
  end

endmodule

// File: tb/tb_osd_dp_packet_buffer.sv
// Scoreboard bench for osd_dp_packet_buffer: directed corner cases followed by
// randomized packets under random backpressure.
module tb_osd_dp_packet_buffer;

  localparam int DEPTH = 16;
  localparam int MAXL  = 8;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   in_data = '0;
  logic          in_last = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   out_data;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] pkt_count;
  logic          trunc_err;
  logic          trunc_err_clr = 1'b0;

  logic rdy_mode  = 1'b0;
  logic rdy_force = 1'b0;
  logic rdy_rand  = 1'b0;
  assign out_ready = rdy_mode ? rdy_rand : rdy_force;

  int total = 0;
  int bad = 0;
  int commits = 0;
  int delivered = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  osd_dp_packet_buffer #(.DEPTH(DEPTH), .MAX_PKT_LEN(MAXL)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .pkt_count(pkt_count), .trunc_err(trunc_err), .trunc_err_clr(trunc_err_clr)
  );

  initial begin : ready_gen
    forever begin
      @(posedge clk);
      #1 rdy_rand = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops expected flits on every egress transfer, checks hold under stall
  initial begin : monitor
    logic        stall;
    logic [16:0] held;
    logic [16:0] e;
    int          expc;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
        continue;
      end
      if (stall) begin
        total++;
        if (!out_valid || {out_last, out_data} != held) begin
          bad++;
          $display("FAIL stall_hold: got v=%0b %h required v=1 %h", out_valid, {out_last, out_data}, held);
        end
      end
      expc = commits - delivered;
      total++;
      if (int'(pkt_count) != expc) begin
        bad++;
        $display("FAIL pkt_count_track: got %0d required %0d", pkt_count, expc);
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_flit: got %h required none", {out_last, out_data});
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_data} != e) begin
            bad++;
            $display("FAIL flit: got last=%0b data=%h required last=%0b data=%h", out_last, out_data, e[16], e[15:0]);
          end
        end
        if (out_last) delivered++;
      end
      stall = out_valid && !out_ready;
      held  = {out_last, out_data};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Called aligned just after a rising edge; returns aligned likewise with in_valid low
  task automatic send_flit(input logic [15:0] d, input logic l, input logic c);
    int   n;
    logic acc;
    in_data = d; in_last = l; in_valid = 1'b1;
    n = 0; acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 3000) begin
        total++; bad++;
        $display("FAIL send_timeout: got no in_ready required accept of %h", d);
        break;
      end
    end
    in_valid = 1'b0;
    if (acc && c) commits++;
  endtask

  task automatic wait_drain(input int maxc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < maxc) begin
      step();
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  initial begin : main
    int          acc_n;
    int          len, eff;
    logic [15:0] d;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_trunc_err", trunc_err, 0);
    step();
    rst_n = 1'b1;
    step();

    // 1: three-flit packet, egress only after the last flit is stored
    rdy_force = 1'b1;
    exp_q.push_back({1'b0, 16'h0010});
    exp_q.push_back({1'b0, 16'h0020});
    exp_q.push_back({1'b1, 16'h0030});
    send_flit(16'h0010, 1'b0, 1'b0);
    @(negedge clk); chk("t1_early1", out_valid, 0); step();
    send_flit(16'h0020, 1'b0, 1'b0);
    @(negedge clk); chk("t1_early2", out_valid, 0); step();
    send_flit(16'h0030, 1'b1, 1'b1);
    @(negedge clk); chk("t1_valid", out_valid, 1); chk("t1_count1", pkt_count, 1); step();
    wait_drain(20);
    @(negedge clk); chk("t1_count0", pkt_count, 0); step();

    // 2: fill with single-flit packets while egress is blocked
    rdy_force = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 20; i++) begin
      in_data = 16'(16'h0200 + i); in_last = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      if (!in_ready) break;
      exp_q.push_back({1'b1, 16'(16'h0200 + i)});
      step();
      acc_n++;
      commits++;
    end
    in_valid = 1'b0;
    step();
    chk("t2_accepted", acc_n, 16);
    @(negedge clk); chk("t2_count16", pkt_count, 16); chk("t2_full", in_ready, 0); step();
    rdy_force = 1'b1;
    step();
    rdy_force = 1'b0;
    @(negedge clk); chk("t2_ready_again", in_ready, 1); chk("t2_count15", pkt_count, 15); step();
    rdy_force = 1'b1;
    wait_drain(100);

    // 3: oversized packet truncated to MAXL flits, then a normal packet
    for (int k = 1; k <= 10; k++) begin
      if (k <= MAXL) exp_q.push_back({k == MAXL, 16'(16'h0300 + k)});
      send_flit(16'(16'h0300 + k), k == 10, k == MAXL);
    end
    @(negedge clk); chk("t3_trunc_set", trunc_err, 1); step();
    exp_q.push_back({1'b0, 16'h0400});
    exp_q.push_back({1'b1, 16'h0401});
    send_flit(16'h0400, 1'b0, 1'b0);
    send_flit(16'h0401, 1'b1, 1'b1);
    wait_drain(50);
    @(negedge clk); chk("t3_trunc_sticky", trunc_err, 1); step();
    trunc_err_clr = 1'b1;
    step();
    trunc_err_clr = 1'b0;
    @(negedge clk); chk("t3_trunc_clr", trunc_err, 0); step();

    // 4: commit of B in the same cycle as egress of A's last flit
    rdy_force = 1'b0;
    exp_q.push_back({1'b1, 16'h0500});
    send_flit(16'h0500, 1'b1, 1'b1);
    exp_q.push_back({1'b0, 16'h0600});
    exp_q.push_back({1'b1, 16'h0601});
    send_flit(16'h0600, 1'b0, 1'b0);
    in_data = 16'h0601; in_last = 1'b1; in_valid = 1'b1;
    rdy_force = 1'b1;
    @(negedge clk); chk("t4_count_before", pkt_count, 1); chk("t4_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; rdy_force = 1'b0; commits++;
    @(negedge clk); chk("t4_count_same", pkt_count, 1); chk("t4_b_head", {out_valid, out_data}, {1'b1, 16'h0600});
    step();
    rdy_force = 1'b1;
    wait_drain(20);

    // 5: reset while two packets are stored and a third is partial
    rdy_force = 1'b0;
    for (int p = 0; p < 2; p++) begin
      exp_q.push_back({1'b0, 16'(16'h0700 + 2 * p)});
      exp_q.push_back({1'b1, 16'(16'h0701 + 2 * p)});
      send_flit(16'(16'h0700 + 2 * p), 1'b0, 1'b0);
      send_flit(16'(16'h0701 + 2 * p), 1'b1, 1'b1);
    end
    send_flit(16'h0720, 1'b0, 1'b0);
    @(negedge clk); chk("t5_count2", pkt_count, 2); step();
    rst_n = 1'b0;
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_count0", pkt_count, 0);
    chk("t5_in_ready", in_ready, 1);
    exp_q.delete();
    commits = 0;
    delivered = 0;
    step();
    step();
    rst_n = 1'b1;
    step();
    rdy_force = 1'b1;
    exp_q.push_back({1'b0, 16'h0800});
    exp_q.push_back({1'b1, 16'h0801});
    send_flit(16'h0800, 1'b0, 1'b0);
    send_flit(16'h0801, 1'b1, 1'b1);
    wait_drain(20);

    // 6: random packets, random gaps and random backpressure
    rdy_mode = 1'b1;
    for (int p = 0; p < 1500; p++) begin
      len = $urandom_range(1, 12);
      eff = (len > MAXL) ? MAXL : len;
      for (int j = 1; j <= len; j++) begin
        d = 16'($urandom);
        if (j <= eff) exp_q.push_back({j == eff, d});
        send_flit(d, j == len, j == eff);
        if ($urandom_range(0, 3) == 0) step();
      end
    end
    wait_drain(5000);
    @(negedge clk); chk("t6_count_end", pkt_count, 0); chk("t6_trunc_seen", trunc_err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
